// File: rtl/ahbl_sram_responder.sv
// ahbl_sram_responder: AHB-Lite SRAM subordinate with programmable wait states and two-cycle ERROR responses.
// Optional write protection of [0, WP_BYTES) is enabled by defining AHBL_SRAM_WP_EN.
module ahbl_sram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WP_BYTES    = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [3:0]    lanes_q, lanes_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [31:0]   mem [DEPTH];
  logic          accept, illegal, wp_hit, busy, load, commit;
  logic [3:0]    lanes;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          unused;
`ifdef AHBL_SRAM_WP_EN
  assign wp_hit = hwrite_i && haddr_i < WP_BYTES;
  assign unused = htrans_i[0];
`else
  assign wp_hit = 1'b0;
  assign unused = htrans_i[0] ^ (^WP_BYTES);
`endif
  assign accept  = hsel_i & hready_i & htrans_i[1];
  assign illegal = hsize_i[2] | (hsize_i[1:0] == 2'b11) | (hsize_i == 3'b001 && haddr_i[0])
                 | (hsize_i == 3'b010 && haddr_i[1:0] != 2'b00) | (haddr_i >= DEPTH * 4) | wp_hit;
  assign lanes   = hsize_i[1] ? 4'hf : hsize_i[0] ? (haddr_i[1] ? 4'hc : 4'h3) : 4'b0001 << haddr_i[1:0];
  assign busy    = state_q == DATA && cnt_q != 3'd0;
  assign load    = accept & ~illegal & ~busy & (state_q != ERR1);
  assign commit  = state_q == DATA && cnt_q == 3'd0 && write_q && !rst_i;
  assign rd_idx  = haddr_i[AW+1:2];
  // A read captured on the edge a write commits to the same word sees the merged bytes.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      rd_word[i*8+:8] = (commit && addr_q == rd_idx && lanes_q[i]) ? hwdata_i[i*8+:8] : rd_word[i*8+:8];
  end
  always_comb begin
    state_d  = state_q == ERR1 ? ERR2 : busy ? DATA : !accept ? IDLE : illegal ? ERR1 : DATA;
    cnt_d    = busy ? cnt_q - 3'd1 : load ? 3'(WAIT_STATES) : 3'd0;
    addr_d   = load ? rd_idx : addr_q;
    write_d  = load ? hwrite_i : write_q;
    lanes_d  = load ? lanes : lanes_q;
    hrdata_d = (load && !hwrite_i) ? rd_word : hrdata_q;
    hready_d = !(state_d == ERR1 || (state_d == DATA && cnt_d != 3'd0));
    hresp_d  = state_d == ERR1 || state_d == ERR2;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      lanes_q  <= 4'h0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      lanes_q  <= lanes_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (commit && lanes_q[i]) mem[addr_q][i*8+:8] <= hwdata_i[i*8+:8];
  end
  assign hreadyout_o = hready_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = hrdata_q;
endmodule
